// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall merge, exception flush sequencing and stall watchdog
// Optional performance counters are built when PIPE_STALL_PERF_CNT_EN is defined.

module pipe_stall_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h00000020,
   parameter int unsigned MAX_STALL  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout
`ifdef PIPE_STALL_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [15:0] perf_flush_count
`endif
);

   typedef enum logic {ST_RUN = 1'b0, ST_PEND = 1'b1} state_t;

   localparam logic [31:0] EXC_ERET     = 32'h0000000e;
   localparam logic [5:0]  STALL_MEM    = 6'b011111;
   localparam logic [5:0]  STALL_EX     = 6'b001111;
   localparam logic [5:0]  STALL_ID     = 6'b000111;
   localparam logic [5:0]  STALL_IF     = 6'b000011;
   localparam logic [15:0] WD_MAX       = 16'(MAX_STALL);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pend_type;
   logic [31:0] pend_epc;
   logic [15:0] wd_cnt;
   logic [15:0] wd_cnt_nxt;
   logic        exc_now;

   // eret returns to EPC; every other exception enters the common handler
   function automatic logic [31:0] redirect_target(input logic [31:0] code, input logic [31:0] epc);
      return (code == EXC_ERET) ? epc : EXC_VECTOR;
   endfunction

   assign exc_now = (excepttype != 32'h0);

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // next state: defer an exception while the data bus is busy, release it once the bus frees
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:  if (exc_now && stallreq_mem) state_nxt = ST_PEND;
         ST_PEND: if (!stallreq_mem)           state_nxt = ST_RUN;
         default: state_nxt = ST_RUN;
      endcase
   end

   // outputs: flush dominates all stall requests; reset forces everything quiet
   always_comb begin
      stall  = 6'b000000;
      flush  = 1'b0;
      new_pc = 32'h0;
      if (!rst) begin
         case (state)
            ST_RUN: begin
               if (exc_now && !stallreq_mem) begin
                  flush  = 1'b1;
                  new_pc = redirect_target(excepttype, cp0_epc);
               end else if (stallreq_mem) begin
                  stall = STALL_MEM;
               end else if (stallreq_ex) begin
                  stall = STALL_EX;
               end else if (stallreq_id) begin
                  stall = STALL_ID;
               end else if (stallreq_if) begin
                  stall = STALL_IF;
               end
            end
            ST_PEND: begin
               if (stallreq_mem) begin
                  stall = STALL_MEM;
               end else begin
                  flush  = 1'b1;
                  new_pc = redirect_target(pend_type, pend_epc);
               end
            end
            default: begin
               stall = 6'b000000;
            end
         endcase
      end
   end

   // capture the oldest exception when it has to wait for the data bus
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_type <= 32'h0;
         pend_epc  <= 32'h0;
      end else if (state == ST_RUN && exc_now && stallreq_mem) begin
         pend_type <= excepttype;
         pend_epc  <= cp0_epc;
      end
   end

   // watchdog count of consecutive stalled cycles, saturating at the limit
   always_comb begin
      wd_cnt_nxt = 16'h0;
      if (stall != 6'b000000 && !flush) begin
         wd_cnt_nxt = (wd_cnt >= WD_MAX) ? WD_MAX : wd_cnt + 16'd1;
      end
   end

   // watchdog register and sticky timeout flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt        <= 16'h0;
         stall_timeout <= 1'b0;
      end else begin
         wd_cnt <= wd_cnt_nxt;
         if (wd_cnt_nxt == WD_MAX) begin
            stall_timeout <= 1'b1;
         end
      end
   end

`ifdef PIPE_STALL_PERF_CNT_EN
   // free-running performance counters, wrapping naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cycles <= 32'h0;
         perf_flush_count  <= 16'h0;
      end else begin
         if (stall != 6'b000000) perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (flush)              perf_flush_count  <= perf_flush_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl against a behavioural model

module tb_pipe_stall_ctrl;

   localparam int MAX_STALL = 16;
   localparam logic [31:0] EXC_VECTOR = 32'h00000020;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallreq_if = 1'b0;
   logic        stallreq_id = 1'b0;
   logic        stallreq_ex = 1'b0;
   logic        stallreq_mem = 1'b0;
   logic [31:0] excepttype = 32'h0;
   logic [31:0] cp0_epc = 32'h0;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        stall_timeout;
`ifdef PIPE_STALL_PERF_CNT_EN
   logic [31:0] perf_stall_cycles;
   logic [15:0] perf_flush_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // model state: a pending exception, the length of the current stall run, the sticky flag
   bit          m_pend = 1'b0;
   logic [31:0] m_ptype = 32'h0;
   logic [31:0] m_pepc = 32'h0;
   int          m_run = 0;
   bit          m_to = 1'b0;
   int unsigned m_pstall = 0;
   int unsigned m_pflush = 0;

   logic [5:0]  o_stall;
   logic        o_flush;
   logic [31:0] o_pc;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.EXC_VECTOR(EXC_VECTOR), .MAX_STALL(MAX_STALL)) dut (
      .clk(clk),
      .rst(rst),
      .stallreq_if(stallreq_if),
      .stallreq_id(stallreq_id),
      .stallreq_ex(stallreq_ex),
      .stallreq_mem(stallreq_mem),
      .excepttype(excepttype),
      .cp0_epc(cp0_epc),
      .stall(stall),
      .flush(flush),
      .new_pc(new_pc),
      .stall_timeout(stall_timeout)
`ifdef PIPE_STALL_PERF_CNT_EN
      ,
      .perf_stall_cycles(perf_stall_cycles),
      .perf_flush_count(perf_flush_count)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // one clock cycle: apply inputs, check combinational outputs, advance model, check registers
   // req = {mem, ex, id, if}
   task automatic step(input logic r, input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc);
      logic [5:0]  e_stall;
      logic        e_flush;
      logic [31:0] e_pc;
      logic [31:0] code;
      logic [31:0] ret;
      @(negedge clk);
      rst = r;
      stallreq_if = req[0];
      stallreq_id = req[1];
      stallreq_ex = req[2];
      stallreq_mem = req[3];
      excepttype = exc;
      cp0_epc = epc;
      #1;
      e_stall = 6'b0;
      e_flush = 1'b0;
      e_pc = 32'h0;
      code = m_pend ? m_ptype : exc;
      ret  = m_pend ? m_pepc : epc;
      if (!r) begin
         if (m_pend || exc != 0) begin
            if (req[3]) e_stall = 6'b011111;
            else begin
               e_flush = 1'b1;
               e_pc = (code == 32'h0000000e) ? ret : EXC_VECTOR;
            end
         end else if (req[3]) e_stall = 6'b011111;
         else if (req[2]) e_stall = 6'b001111;
         else if (req[1]) e_stall = 6'b000111;
         else if (req[0]) e_stall = 6'b000011;
      end
      o_stall = stall;
      o_flush = flush;
      o_pc = new_pc;
      check_eq("stall", {26'h0, stall}, {26'h0, e_stall});
      check_eq("flush", {31'h0, flush}, {31'h0, e_flush});
      if (e_flush || r) check_eq("new_pc", new_pc, e_pc);
      @(posedge clk);
      if (r) begin
         m_pend = 1'b0;
         m_run = 0;
         m_to = 1'b0;
         m_pstall = 0;
         m_pflush = 0;
      end else begin
         if (e_stall != 0 && !e_flush) m_run++;
         else m_run = 0;
         if (m_run >= MAX_STALL) m_to = 1'b1;
         if (e_stall != 0) m_pstall++;
         if (e_flush) m_pflush++;
         if (!m_pend && exc != 0 && req[3]) begin
            m_pend = 1'b1;
            m_ptype = exc;
            m_pepc = epc;
         end else if (m_pend && !req[3]) begin
            m_pend = 1'b0;
         end
      end
      #1;
      check_eq("stall_timeout", {31'h0, stall_timeout}, {31'h0, m_to});
`ifdef PIPE_STALL_PERF_CNT_EN
      check_eq("perf_stall", perf_stall_cycles, m_pstall);
      check_eq("perf_flush", {16'h0, perf_flush_count}, m_pflush & 32'hffff);
`endif
   endtask

   initial begin
      logic [3:0]  req;
      logic [31:0] exc;
      int          pick;

      step(1'b1, 4'b0000, 32'h0, 32'h0);
      step(1'b1, 4'b1111, 32'h8, 32'h0);
      check_eq("reset_stall", {26'h0, o_stall}, 32'h0);
      check_eq("reset_timeout", {31'h0, stall_timeout}, 32'h0);

      // priority merge
      step(1'b0, 4'b0110, 32'h0, 32'h0);
      check_eq("prio_ex_id", {26'h0, o_stall}, 32'h0000000f);
      step(1'b0, 4'b0001, 32'h0, 32'h0);
      check_eq("prio_if", {26'h0, o_stall}, 32'h00000003);

      // plain exception and eret
      step(1'b0, 4'b0111, 32'h00000008, 32'h0);
      check_eq("exc_flush", {31'h0, o_flush}, 32'h1);
      check_eq("exc_pc", o_pc, 32'h00000020);
      check_eq("exc_stall", {26'h0, o_stall}, 32'h0);
      step(1'b0, 4'b0000, 32'h0, 32'h0);
      check_eq("exc_after", {31'h0, o_flush}, 32'h0);
      step(1'b0, 4'b0000, 32'h0000000e, 32'h00001234);
      check_eq("eret_pc", o_pc, 32'h00001234);

      // deferred exception, first one wins
      step(1'b0, 4'b1000, 32'h0000000c, 32'h0);
      check_eq("defer1", {25'h0, o_flush, o_stall}, 32'h1f);
      step(1'b0, 4'b1000, 32'h0000000e, 32'h00005555);
      check_eq("defer2", {25'h0, o_flush, o_stall}, 32'h1f);
      step(1'b0, 4'b1000, 32'h0, 32'h0);
      check_eq("defer3", {25'h0, o_flush, o_stall}, 32'h1f);
      step(1'b0, 4'b0000, 32'h0, 32'h0);
      check_eq("defer_flush", {31'h0, o_flush}, 32'h1);
      check_eq("defer_pc", o_pc, 32'h00000020);

      // watchdog
      for (int i = 0; i < MAX_STALL; i++) begin
         step(1'b0, 4'b0100, 32'h0, 32'h0);
         if (i == MAX_STALL - 2) check_eq("wd_early", {31'h0, stall_timeout}, 32'h0);
      end
      check_eq("wd_set", {31'h0, stall_timeout}, 32'h1);
      step(1'b0, 4'b0000, 32'h0, 32'h0);
      step(1'b0, 4'b0000, 32'h0, 32'h0);
      check_eq("wd_sticky", {31'h0, stall_timeout}, 32'h1);

      // reset mid-PEND
      step(1'b0, 4'b1000, 32'h0000000c, 32'h0);
      step(1'b1, 4'b1000, 32'h0, 32'h0);
      check_eq("rstpend_out", {25'h0, o_flush, o_stall}, 32'h0);
      step(1'b0, 4'b0000, 32'h0, 32'h0);
      check_eq("rstpend_noflush", {31'h0, o_flush}, 32'h0);
      check_eq("rstpend_timeout", {31'h0, stall_timeout}, 32'h0);

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         req = 4'($urandom);
         req[3] = ($urandom_range(0, 99) < 35);
         pick = $urandom_range(0, 9);
         if (pick < 7) exc = 32'h0;
         else if (pick == 7) exc = 32'h00000008;
         else if (pick == 8) exc = 32'h0000000e;
         else exc = $urandom | 32'h1;
         if ($urandom_range(0, 99) < 15) req = 4'b0000;
         step(($urandom_range(0, 99) < 2), req, exc, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS32 core.
- Merges per-stage stall requests into the 6-bit stall bus consumed by pc_reg and every pipeline register: if_id, id_ex, ex_mem and mem_wb.
- Sequences exception flushes from the MEM stage, deferring them while the data bus is still busy.
- Runs a stall watchdog.

Parameters:
- EXC_VECTOR, 32'h00000020, exception handler entry address.
- MAX_STALL, 16, consecutive stalled cycles before stall_timeout sets (1..65535).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high (`RstEnable = 1'b1).
- stallreq_if  in  1  fetch bus wait.
- stallreq_id  in  1  ID-stage load-use hazard.
- stallreq_ex  in  1  EX multi-cycle op (div/madd).
- stallreq_mem  in  1  data bus wait.
- excepttype  in  32  MEM-stage exception code; 0 = none.
- cp0_epc  in  32  current EPC from CP0.
- stall  out  6  bit0 pc, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = `Stop.
- flush  out  1  one-cycle pipeline flush.
- new_pc  out  32  redirect target, valid only while flush=1.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high.
- Reset values: state=RUN; pend_type=0; pend_epc=0; wd_cnt=0; stall_timeout=0.
  - While rst=1, combinational outputs are forced: stall=6'b000000, flush=0, new_pc=0.
- stall, flush and new_pc are combinational from inputs and state, with zero-cycle latency. All other state is registered.
- Stall merge (RUN, no flush), highest priority first:
  - stallreq_mem -> 6'b011111
  - stallreq_ex -> 6'b001111
  - stallreq_id -> 6'b000111
  - stallreq_if -> 6'b000011
  - none -> 6'b000000
- Target mapping: excepttype==32'h0000000e (eret) -> new_pc=cp0_epc; any other nonzero code -> new_pc=EXC_VECTOR.
- FSM states: RUN, PEND.
- RUN, excepttype!=0 and stallreq_mem=0:
  - flush=1, stall=6'b000000, new_pc from current excepttype/cp0_epc.
  - Stay in RUN.
- RUN, excepttype!=0 and stallreq_mem=1:
  - flush=0, stall=6'b011111.
  - Latch pend_type<=excepttype and pend_epc<=cp0_epc.
  - Next state PEND.
- PEND, stallreq_mem=1:
  - stall=6'b011111, flush=0.
  - New excepttype values are ignored; the latched exception is oldest and wins.
- PEND, stallreq_mem=0:
  - flush=1, stall=0, new_pc from pend_type/pend_epc.
  - Next state RUN.
  - pend_type/pend_epc hold their values and are overwritten only by the next latch.
- Simultaneous events:
  - flush overrides every stall request in the same cycle.
  - stallreq_if/id/ex are ignored while flush=1.
- Watchdog:
  - wd_cnt (16 bit) increments each cycle stall!=0 and flush=0.
  - Clears to 0 on any cycle with stall==0 or flush=1.
  - Saturates at MAX_STALL.
  - stall_timeout sets on the cycle wd_cnt reaches MAX_STALL and stays 1 until rst.
- Reset mid-PEND: the pending exception is discarded and no flush is issued. The FSM returns to RUN on the next edge.

Optional Feature:
- Macro: PIPE_STALL_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - perf_stall_cycles (32): increments every cycle stall!=0.
  - perf_flush_count (16): increments every cycle flush=1.
  - Both reset to 0, wrap modulo 2^N, and clear on rst.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Priority: stallreq_id=1 and stallreq_ex=1 -> stall=6'b001111. Then only stallreq_if=1 -> 6'b000011.
- Plain exception: excepttype=32'h00000008, stallreq_mem=0 -> same cycle flush=1, new_pc=32'h00000020, stall=0. Next cycle flush=0.
- eret: excepttype=32'h0000000e, cp0_epc=32'h00001234 -> flush=1, new_pc=32'h00001234.
- Deferred exception:
  - Stimulus: stallreq_mem=1 for 3 cycles with excepttype=32'h0000000c on the first; second exception 32'h0000000e appears on cycle 2.
  - Response: stall=6'b011111 for 3 cycles, flush=0 throughout.
  - Cycle 4 (stallreq_mem=0): flush=1, new_pc=32'h00000020 (first exception wins).
- Watchdog: MAX_STALL=16, stallreq_ex=1 for 16 cycles -> stall_timeout rises after the 16th stalled cycle. Drop all requests -> stall_timeout stays 1.
- Reset mid-PEND: enter PEND, then pulse rst=1 for 1 cycle -> stall=0, flush=0. Afterwards no flush with stallreq_mem=0 and excepttype=0. stall_timeout=0.
